// File: rtl/bomb_module.sv
// Single-bomb lifecycle (place, fuse, explosion, post-explosion) with per-pixel bomb and
// cross-shaped blast coverage clipped by the arena edges and the odd/odd pillar grid.
module bomb_module #(
  parameter int unsigned ARENA_X0    = 48,
  parameter int unsigned ARENA_Y0    = 32,
  parameter int unsigned TILE        = 16,
  parameter int unsigned ARENA_W     = 33,
  parameter int unsigned ARENA_H     = 27,
  parameter int unsigned EXP_LEN     = 2,
  parameter int unsigned FUSE_CYCLES = 50000000,
  parameter int unsigned EXP_CYCLES  = 12500000,
  parameter int unsigned POST_CYCLES = 6250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] x_b,
  input  logic [9:0] y_b,
  input  logic       place_btn,
  output logic       bomb_on,
  output logic       exp_on,
  output logic       post_exp_active,
  output logic       bomb_active
);

  localparam int unsigned TShift = $clog2(TILE);
  localparam int unsigned CntW   = 26;

  typedef enum logic [1:0] {StIdle, StFuse, StExp, StPost} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
  logic [2:0]      up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic            btn_prev_q;
  logic            press;

  // Arm length saturated at EXP_LEN; room never exceeds the arena so the low bits suffice.
  function automatic logic [2:0] arm_len(input logic [10:0] room);
    return (room >= 11'(EXP_LEN)) ? 3'(EXP_LEN) : room[2:0];
  endfunction

  // Bomberman centre tile, computed 11 bits wide so x_b near 1023 cannot wrap.
  logic [10:0] xc_sum, yc_sum, cx, cy, bx, by;
  logic        pos_valid;

  always_comb begin
    xc_sum    = {1'b0, x_b} + 11'(TILE / 2);
    yc_sum    = {1'b0, y_b} + 11'(TILE / 2);
    cx        = xc_sum - 11'(ARENA_X0);
    cy        = yc_sum - 11'(ARENA_Y0);
    bx        = cx >> TShift;
    by        = cy >> TShift;
    pos_valid = (xc_sum >= 11'(ARENA_X0)) && (yc_sum >= 11'(ARENA_Y0)) &&
                (bx < 11'(ARENA_W)) && (by < 11'(ARENA_H));
  end

  assign press = place_btn & ~btn_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bomb_x_d = bomb_x_q;
    bomb_y_d = bomb_y_q;
    up_d     = up_q;
    down_d   = down_q;
    left_d   = left_q;
    right_d  = right_q;
    unique case (state_q)
      StIdle: begin
        if (press && pos_valid) begin
          state_d  = StFuse;
          cnt_d    = '0;
          bomb_x_d = bx[5:0];
          bomb_y_d = by[5:0];
          // An odd column/row means the neighbouring tiles along that axis are pillars.
          up_d     = bx[0] ? 3'd0 : arm_len(by);
          down_d   = bx[0] ? 3'd0 : arm_len(11'(ARENA_H - 1) - by);
          left_d   = by[0] ? 3'd0 : arm_len(bx);
          right_d  = by[0] ? 3'd0 : arm_len(11'(ARENA_W - 1) - bx);
        end
      end
      StFuse: begin
        if (cnt_q == CntW'(FUSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StExp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExp: begin
        if (cnt_q == CntW'(EXP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StPost;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPost: begin
        if (cnt_q == CntW'(POST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bomb_x_q   <= '0;
      bomb_y_q   <= '0;
      up_q       <= '0;
      down_q     <= '0;
      left_q     <= '0;
      right_q    <= '0;
      btn_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bomb_x_q   <= bomb_x_d;
      bomb_y_q   <= bomb_y_d;
      up_q       <= up_d;
      down_q     <= down_d;
      left_q     <= left_d;
      right_q    <= right_d;
      btn_prev_q <= place_btn;
    end
  end

  // Current pixel tile; blast bounds are compared in 7 bits so bomb-arm never underflows.
  logic [9:0] px, py;
  logic       in_arena;
  logic [6:0] px7, py7, bx7, by7, lo_y, hi_y, lo_x, hi_x;
  logic       in_col, in_row;

  always_comb begin
    px       = (x - 10'(ARENA_X0)) >> TShift;
    py       = (y - 10'(ARENA_Y0)) >> TShift;
    in_arena = (x >= 10'(ARENA_X0)) && (y >= 10'(ARENA_Y0)) &&
               (px < 10'(ARENA_W)) && (py < 10'(ARENA_H));
    px7      = px[6:0];
    py7      = py[6:0];
    bx7      = {1'b0, bomb_x_q};
    by7      = {1'b0, bomb_y_q};
    lo_y     = by7 - {4'd0, up_q};
    hi_y     = by7 + {4'd0, down_q};
    lo_x     = bx7 - {4'd0, left_q};
    hi_x     = bx7 + {4'd0, right_q};
    in_col   = (px7 == bx7) && (py7 >= lo_y) && (py7 <= hi_y);
    in_row   = (py7 == by7) && (px7 >= lo_x) && (px7 <= hi_x);
  end

  assign bomb_on         = (state_q == StFuse) && in_arena && (px7 == bx7) && (py7 == by7);
  assign exp_on          = (state_q == StExp) && in_arena && (in_col || in_row);
  assign post_exp_active = (state_q == StExp) || (state_q == StPost);
  assign bomb_active     = (state_q != StIdle);

endmodule

// File: tb/tb_bomb_module.sv
// Self-checking bench for bomb_module: vector table of bomb/pixel placements checked against a
// cycle-indexed phase model through a scoreboard queue, plus reset and re-press sequences.
module tb_bomb_module;

  localparam int unsigned Fuse = 10;
  localparam int unsigned Expc = 6;
  localparam int unsigned Post = 4;

  logic       clk, reset_n, place_btn;
  logic [9:0] x, y, x_b, y_b;
  logic       bomb_on, exp_on, post_exp_active, bomb_active;

  bomb_module #(
    .EXP_LEN    (2),
    .FUSE_CYCLES(Fuse),
    .EXP_CYCLES (Expc),
    .POST_CYCLES(Post)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .x              (x),
    .y              (y),
    .x_b            (x_b),
    .y_b            (y_b),
    .place_btn      (place_btn),
    .bomb_on        (bomb_on),
    .exp_on         (exp_on),
    .post_exp_active(post_exp_active),
    .bomb_active    (bomb_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic e;
    logic p;
    logic a;
  } outs_t;

  typedef struct {
    logic [9:0] xb;
    logic [9:0] yb;
    logic [9:0] px;
    logic [9:0] py;
    logic       eb;
    logic       ee;
  } vec_t;

  outs_t sb_q[$];
  vec_t  vecs[15];
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic chk(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Pushes the expectation for this cycle, then pops and compares at the falling edge.
  task automatic expect_cycle(input string name, input outs_t e);
    outs_t w;
    sb_q.push_back(e);
    @(negedge clk);
    w = sb_q.pop_front();
    chk({name, ".bomb_on"}, bomb_on, w.b);
    chk({name, ".exp_on"}, exp_on, w.e);
    chk({name, ".post_exp_active"}, post_exp_active, w.p);
    chk({name, ".bomb_active"}, bomb_active, w.a);
  endtask

  // Expected outputs j cycles after the placing edge (j=1 is the first FUSE cycle).
  function automatic outs_t phase(input int j, input logic eb, input logic ee);
    outs_t o;
    o.b = eb && (j >= 1) && (j <= Fuse);
    o.e = ee && (j > Fuse) && (j <= Fuse + Expc);
    o.p = (j > Fuse) && (j <= Fuse + Expc + Post);
    o.a = (j >= 1) && (j <= Fuse + Expc + Post);
    return o;
  endfunction

  task automatic idle_cycles(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      expect_cycle(name, '0);
      @(posedge clk);
      #1;
    end
  endtask

  // Entered #1 after a posedge with place_btn low. Mode 1 adds presses in FUSE/EXP and holds
  // the button from POST through the return to IDLE.
  task automatic run_bomb(input string name, input vec_t v, input int mode);
    x_b = v.xb;
    y_b = v.yb;
    x   = v.px;
    y   = v.py;
    place_btn = 1'b1;
    @(posedge clk);
    #1;
    place_btn = 1'b0;
    for (int j = 1; j <= int'(Fuse + Expc + Post) + 1; j++) begin
      if (mode == 1) place_btn = (j == 3) || (j == 12) || (j >= 18);
      expect_cycle(name, phase(j, v.eb, v.ee));
      @(posedge clk);
      #1;
    end
  endtask

  vec_t inval[3];

  initial begin
    vecs[0]  = '{10'd112, 10'd96, 10'd150, 10'd100, 1'b0, 1'b1};
    vecs[1]  = '{10'd112, 10'd96, 10'd115, 10'd70,  1'b0, 1'b1};
    vecs[2]  = '{10'd112, 10'd96, 10'd162, 10'd100, 1'b0, 1'b0};
    vecs[3]  = '{10'd112, 10'd96, 10'd115, 10'd100, 1'b1, 1'b1};
    vecs[4]  = '{10'd112, 10'd96, 10'd115, 10'd52,  1'b0, 1'b0};
    vecs[5]  = '{10'd96,  10'd96, 10'd100, 10'd84,  1'b0, 1'b0};
    vecs[6]  = '{10'd96,  10'd96, 10'd130, 10'd100, 1'b0, 1'b1};
    vecs[7]  = '{10'd96,  10'd96, 10'd100, 10'd100, 1'b1, 1'b1};
    vecs[8]  = '{10'd40,  10'd24, 10'd40,  10'd40,  1'b0, 1'b0};
    vecs[9]  = '{10'd40,  10'd24, 10'd70,  10'd40,  1'b0, 1'b1};
    vecs[10] = '{10'd40,  10'd24, 10'd90,  10'd40,  1'b0, 1'b1};
    vecs[11] = '{10'd40,  10'd24, 10'd50,  10'd70,  1'b0, 1'b1};
    vecs[12] = '{10'd40,  10'd24, 10'd50,  10'd100, 1'b0, 1'b0};
    vecs[13] = '{10'd552, 10'd24, 10'd580, 10'd40,  1'b0, 1'b0};
    vecs[14] = '{10'd552, 10'd24, 10'd530, 10'd40,  1'b0, 1'b1};
    // Off-arena bomberman positions: left/top edge, column 33, row 27.
    inval[0] = '{10'd0,   10'd0,  10'd0, 10'd0, 1'b0, 1'b0};
    inval[1] = '{10'd568, 10'd96, 10'd0, 10'd0, 1'b0, 1'b0};
    inval[2] = '{10'd112, 10'd456, 10'd0, 10'd0, 1'b0, 1'b0};

    // Reset with the button held: outputs low and no placement once reset lifts.
    reset_n   = 1'b1;
    place_btn = 1'b1;
    x_b = 10'd112;
    y_b = 10'd96;
    x   = 10'd115;
    y   = 10'd100;
    #1;
    reset_n = 1'b0;
    #2;
    chk("reset.bomb_active", bomb_active, 1'b0);
    chk("reset.post_exp_active", post_exp_active, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles("held_through_reset", 3);
    place_btn = 1'b0;
    idle_cycles("released", 1);

    // Full-duration walk at the bomb tile, then the vector table.
    run_bomb("centre_walk", vecs[3], 0);
    for (int i = 0; i < 15; i++) run_bomb($sformatf("vec%0d", i), vecs[i], 0);

    for (int i = 0; i < 3; i++) begin
      x_b = inval[i].xb;
      y_b = inval[i].yb;
      place_btn = 1'b1;
      @(posedge clk);
      #1;
      place_btn = 1'b0;
      idle_cycles($sformatf("invalid%0d", i), 2);
    end

    // Extra presses ignored; button held across the return to IDLE must not re-place.
    run_bomb("repress", vecs[3], 1);
    idle_cycles("held_into_idle", 3);
    place_btn = 1'b0;
    idle_cycles("held_release", 1);
    place_btn = 1'b1;
    @(posedge clk);
    #1;
    place_btn = 1'b0;
    for (int j = 1; j <= int'(Fuse) + 2; j++) begin
      expect_cycle("fresh_edge", phase(j, 1'b1, 1'b1));
      @(posedge clk);
      #1;
    end

    // Now in the third EXP cycle: reset must clear outputs before the next edge.
    chk("pre_reset.exp_on", exp_on, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_reset.exp_on", exp_on, 1'b0);
    chk("async_reset.post_exp_active", post_exp_active, 1'b0);
    chk("async_reset.bomb_active", bomb_active, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles("after_reset", 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
